// File: rtl/fir8_order.sv
// 9-tap direct-form FIR with fixed symmetric coefficients 1,3,5,7,9,7,5,3,1.
// Registered output, one new sample per clock, synchronous active-high reset.
module fir8_order #(
  parameter int DATA_W = 4,
  parameter int OUT_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Data_in,
  output logic [OUT_W-1:0]  Data_out
);

  localparam int NTAPS = 9;
  // Coefficients sum to 41 < 2**6, so six guard bits hold the full sum.
  localparam int ACC_W = DATA_W + 6;

  localparam logic [3:0] H [NTAPS] = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9,
                                       4'd7, 4'd5, 4'd3, 4'd1};

  logic [DATA_W-1:0] x_q [NTAPS];
  logic [DATA_W-1:0] x_d [NTAPS];
  logic [ACC_W-1:0]  acc;
  logic [OUT_W-1:0]  data_out_q;
  logic [OUT_W-1:0]  data_out_d;

  always_comb begin
    x_d[0] = Data_in;
    for (int k = 1; k < NTAPS; k++) begin
      x_d[k] = x_q[k-1];
    end
  end

  // NOTE: acc is given a value before the loop accumulates into it, so no
  // path through this block leaves it unassigned and no latch is inferred.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NTAPS; k++) begin
      acc = acc + ACC_W'(x_q[k]) * ACC_W'(H[k]);
    end
    data_out_d = OUT_W'(acc);
  end

  // NOTE: state registers use non-blocking assignments so every tap shifts
  // from the values held before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the delay line is cleared on reset because stale samples would
      // otherwise leak into the output after release.
      for (int k = 0; k < NTAPS; k++) begin
        x_q[k] <= '0;
      end
      data_out_q <= '0;
    end else begin
      x_q        <= x_d;
      data_out_q <= data_out_d;
    end
  end

  assign Data_out = data_out_q;

endmodule

// File: tb/tb_fir8_order.sv
// Self-checking bench for fir8_order: directed vector table plus ramp and
// random stimulus compared against a convolution model of sample history.
module tb_fir8_order;

  localparam int DATA_W = 4;
  localparam int OUT_W  = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] Data_in;
  logic [OUT_W-1:0]  Data_out;

  int n_checks = 0;
  int n_fail   = 0;

  fir8_order #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .Data_in  (Data_in),
    .Data_out (Data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    int din;
    int exp;   // -1: no fixed constant, checked against the model only
  } vec_t;

  vec_t vecs[$];
  int   coef[9] = '{1, 3, 5, 7, 9, 7, 5, 3, 1};
  int   hist[$];  // samples accepted since the last reset, newest last

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Output after an edge = sum of coef[k] * (sample accepted k+1 edges ago).
  task automatic model_step(input bit r, input int d, output int y);
    y = 0;
    if (r) begin
      hist.delete();
    end else begin
      for (int k = 0; k < 9; k++) begin
        if (k < hist.size()) y += coef[k] * hist[hist.size() - 1 - k];
      end
      hist.push_back(d);
      if (hist.size() > 9) void'(hist.pop_front());
    end
  endtask

  task automatic apply(input string name, input bit r, input int d, input int exp_c);
    int y;
    reset   = r;
    Data_in = DATA_W'(d);
    model_step(r, d, y);
    @(posedge clk);
    #1;
    if (exp_c >= 0) check({name, "_vec"}, int'(Data_out), exp_c);
    check({name, "_model"}, int'(Data_out), y);
  endtask

  task automatic add(input bit r, input int d, input int e);
    vec_t v;
    v.rst = r; v.din = d; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    int impulse[9] = '{1, 3, 5, 7, 9, 7, 5, 3, 1};
    int step[9]    = '{15, 60, 135, 240, 375, 480, 555, 600, 615};

    reset   = 1'b1;
    Data_in = '0;

    // Reset held two edges with full-scale input, then release with impulse.
    add(1, 15, 0);
    add(1, 15, 0);
    add(0, 1, 0);
    for (int i = 0; i < 9; i++) add(0, 0, impulse[i]);
    add(0, 0, 0);
    // Max step from an empty line, then steady state.
    add(0, 15, 0);
    for (int i = 0; i < 9; i++) add(0, 15, step[i]);
    add(0, 15, 615);
    add(0, 15, 615);
    // Mid-run reset from 615 discards all history.
    add(1, 15, 0);
    add(0, 15, 0);
    add(0, 15, 15);
    add(0, 15, 60);
    add(0, 15, 135);
    // Alternating 0/15 after a fresh reset.
    add(1, 0, 0);
    for (int m = 1; m <= 14; m++) begin
      int e;
      if (m < 10) e = -1;
      else        e = (m % 2 == 0) ? 315 : 300;
      add(0, (m % 2 == 1) ? 15 : 0, e);
    end

    foreach (vecs[i]) apply($sformatf("v%0d", i), vecs[i].rst, vecs[i].din, vecs[i].exp);

    // Ramp wrapping 15 -> 0 several times.
    apply("ramp_rst", 1'b1, 0, 0);
    for (int i = 0; i < 48; i++) apply($sformatf("ramp%0d", i), 1'b0, i % 16, -1);

    // Random samples with occasional resets.
    for (int i = 0; i < 400; i++) begin
      bit r;
      r = ($urandom_range(0, 15) == 0);
      apply($sformatf("rnd%0d", i), r, int'($urandom_range(0, 15)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
